multicycle_main_fsm: RTL

//  Parametrised multicycle control FSM for the ARM-subset datapath. Replaces the

---
 rtl/multicycle_main_fsm.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_main_fsm.sv
// Multicycle main control FSM for the ARM-subset datapath: sequences fetch/decode/execute/writeback,
// waits on memory with a bounded wait-state counter, traps undefined ops, and counts retirements.
module multicycle_main_fsm #(
    parameter int MEM_HANDSHAKE = 1,
    parameter int TIMEOUT       = 16,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             IRWrite,
    output logic             NextPC,
    output logic             Branch,
    output logic             RegW,
    output logic             MemW,
    output logic             AdrSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic             ALUOp,
    output logic             Retire,
    output logic [CNT_W-1:0] RetireCnt,
    output logic             Fault,
    output logic [3:0]       State
);

    localparam int WAIT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_FAULT    = 4'd10
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [WAIT_W-1:0]   wait_cnt_reg;
    logic [WAIT_W-1:0]   wait_cnt_next;
    logic [CNT_W-1:0]    retire_cnt_reg;

    logic done;
    logic is_mem_state;
    logic timeout_hit;
    logic unused_funct;

    assign done         = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;
    assign is_mem_state = (state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                          (state_reg == S_MEMWRITE);
    // The counter holds the number of completed wait cycles, so TIMEOUT waits are tolerated and
    // the next undone cycle traps; a done in that same cycle still lets the access complete.
    assign timeout_hit  = (TIMEOUT != 0) && is_mem_state && !done &&
                          (wait_cnt_reg == WAIT_W'(TIMEOUT));
    assign unused_funct = ^Funct[4:1];

    // State register and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_FETCH;
            wait_cnt_reg   <= '0;
            retire_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (Retire) begin
                retire_cnt_reg <= retire_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_FETCH: begin
                if (done)             state_next = S_DECODE;
                else if (timeout_hit) state_next = S_FAULT;
            end
            S_DECODE: begin
                unique case (Op)
                    2'b00:   state_next = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_next = S_MEMADR;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_FAULT;
                endcase
            end
            S_MEMADR:   state_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (done)             state_next = S_MEMWB;
                else if (timeout_hit) state_next = S_FAULT;
            end
            S_MEMWRITE: begin
                if (done)             state_next = S_FETCH;
                else if (timeout_hit) state_next = S_FAULT;
            end
            S_EXECR, S_EXECI:            state_next = S_ALUWB;
            S_ALUWB, S_MEMWB, S_BRANCH:  state_next = S_FETCH;
            S_FAULT:                     state_next = S_FAULT;
            default:                     state_next = S_FAULT;
        endcase

        // Restart the wait count whenever a new state is entered
        wait_cnt_next = wait_cnt_reg;
        if (state_next != state_reg) begin
            wait_cnt_next = '0;
        end else if (is_mem_state && !done) begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
    end

    // Output logic: Moore decode, with IRWrite/NextPC qualified by memory completion
    always_comb begin
        MemReq    = 1'b0;
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        Branch    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        Retire    = 1'b0;
        if (!reset) begin
            unique case (state_reg)
                S_FETCH: begin
                    MemReq    = 1'b1;
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                    IRWrite   = done;
                    NextPC    = done;
                end
                S_DECODE: begin
                    ALUSrcA   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_MEMADR: begin
                    ALUSrcB = 2'b01;
                end
                S_MEMREAD: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegW      = 1'b1;
                    Retire    = 1'b1;
                end
                S_MEMWRITE: begin
                    MemReq = 1'b1;
                    AdrSrc = 1'b1;
                    MemW   = 1'b1;
                    Retire = done;
                end
                S_EXECR: begin
                    ALUOp = 1'b1;
                end
                S_EXECI: begin
                    ALUSrcB = 2'b01;
                    ALUOp   = 1'b1;
                end
                S_ALUWB: begin
                    RegW   = 1'b1;
                    Retire = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcB   = 2'b01;
                    ResultSrc = 2'b10;
                    Branch    = 1'b1;
                    Retire    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Fault     = (state_reg == S_FAULT);
    assign State     = state_reg;
    assign RetireCnt = retire_cnt_reg;

endmodule
